fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core.
- Owns the program counter and drives the instruction memory address.
- Captures each returned word with its PC into a 2-entry fetch queue.
- Presents queued words to decode over a valid/ready handshake.
- On a branch or jump redirect, flushes queued words and restarts fetch at the redirect target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  32  byte address to instruction memory; always equals current PC
- imem_data  in  32  little-endian word from instruction memory; combinational, valid in the same cycle as imem_addr
- redirect_valid  in  1  one-cycle pulse; load redirect_pc as the new PC
- redirect_pc  in  32  redirect target byte address
- out_valid  out  1  queue head holds a valid fetched word
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  32  head instruction word
- out_pc  out  32  PC of the head instruction
- out_exc  out  1  head entry is a misaligned-fetch exception (see Configuration)

## Operation
- State: pc[31:0], 2-entry circular queue of {pc, instr, exc}, rd_ptr, wr_ptr, count[1:0], halt flag.
- deq = out_valid && out_ready.
- enq = !halt && (count < 2 || deq).
- Per clock edge, in priority order:
  1. redirect_valid:
     - pc <= redirect_pc; count <= 0; pointers <= 0; halt <= 0.
     - No enqueue or dequeue takes effect that cycle.
  2. Otherwise:
     - If enq: write {pc, imem_data, 0} at wr_ptr; pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
     - If deq: advance rd_ptr.
     - count updates by enq - deq.
- Full queue (count == 2) with no deq: pc holds; imem_addr stays stable.
- Empty queue: out_valid = 0; out_instr, out_pc and out_exc hold the last head contents, and decode must ignore them.
- Outputs out_* come directly from queue registers, with no combinational path from imem_data.
- Reset values:
  - pc = RESET_PC; imem_addr = RESET_PC.
  - count = 0; out_valid = 0.
  - out_instr = 0; out_pc = 0; out_exc = 0; halt = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Timing
- Fetch-to-output latency is 1 cycle: the word at pc is visible on out_instr the cycle after the edge that captured it.
- Throughput is 1 instruction/cycle with out_ready held high.
- Simultaneous enqueue and dequeue at count == 2 is allowed; count stays 2.
- After redirect:
  - out_valid = 0 in the cycle following the redirect edge.
  - The first word from the target appears 2 cycles after the redirect pulse.
  - The redirect cycle does not fetch.
- First cycle after reset release: the edge captures the word at RESET_PC, and out_valid rises in the next cycle.
- out_valid never drops without a dequeue or a redirect.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0] != 0 loads the PC unmodified.
  - Next enqueue writes {pc, 32'h0000_0013, exc=1} and sets halt.
  - While halted, no further fetch occurs; pc holds.
  - The next redirect clears halt.
- FETCH_MISALIGN_TRAP_EN undefined:
  - redirect_pc[1:0] is forced to 0 on load.
  - out_exc is tied 0 and halt never sets.

## Test plan
- Reset release, RESET_PC=0, memory words 0x11,0x22,0x33 at 0,4,8, out_ready=1 -> out_valid rises cycle 1; out_pc/out_instr sequence 0/0x11, 4/0x22, 8/0x33 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after first valid -> count saturates at 2, imem_addr frozen at 8, head stays pc 0; on out_ready=1, words 0 and 4 drain, then 8, with no loss or duplication.
- Redirect to 0x100 while queue full and out_ready=1 -> next cycle out_valid=0; following cycle out_pc=0x100; no stale word from old stream ever appears.
- Wrap: redirect to 32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
- Misaligned redirect to 0x102:
  - With macro: one entry out_pc=0x102, out_exc=1, out_instr=0x13; then out_valid stays 0 until a redirect to 0x200 resumes fetch.
  - Without macro: out_pc=0x100, out_exc=0.
- Assert rst_n low mid-stream between clock edges -> out_valid=0 and imem_addr=RESET_PC immediately; fetch restarts cleanly on release.

Source files
------------

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Groups the instruction-memory bus, the redirect request and the decode-side
// valid/ready handshake of the fetch stage into one bundle.
//
// Signals:
//   imem_addr       byte address to instruction memory (driven by fetch)
//   imem_data       combinational instruction word for imem_addr
//   redirect_valid  one-cycle redirect pulse from branch/jump resolution
//   redirect_pc     redirect target byte address
//   out_valid       queue head holds a fetched word
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction word
//   out_pc          PC of the head instruction
//   out_exc         head entry is a misaligned-fetch exception
//
// Modports:
//   master  the fetch unit side
//   slave   the memory / core / decode side
// -----------------------------------------------------------------------------
interface fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_exc;

   modport master (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_exc
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_exc
   );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the program counter, drives the instruction
// memory address, captures each returned word with its PC into a 2-entry
// queue and presents the queue head to decode over valid/ready. A redirect
// flushes the queue and restarts fetch at the target.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master (imem bus, redirect, decode handshake)
//
// Configuration macro:
//   FETCH_MISALIGN_TRAP_EN  when defined, a misaligned PC enqueues one
//                           exception entry (instr = NOP 0x13, exc = 1) and
//                           halts fetch until the next redirect. When not
//                           defined, redirect targets are forced word-aligned
//                           and out_exc is always 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  bus
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } entry_t;

   localparam logic [31:0] TRAP_INSTR = 32'h0000_0013;

   // Architectural state
   entry_t      r_q [2];
   entry_t      r_head;
   logic [31:0] r_pc;
   logic        r_rd_ptr;
   logic        r_wr_ptr;
   logic [1:0]  r_count;
   logic        r_halt;

   // Next-state / control
   logic        w_deq;
   logic        w_enq;
   logic        w_misalign;
   logic [31:0] w_redirect_pc;
   entry_t      w_new;
   logic        w_rd_ptr_next;
   logic [1:0]  w_count_next;
   entry_t      w_head_next;
   logic        w_head_load;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_misalign    = (r_pc[1:0] != 2'b00);
   assign w_redirect_pc = bus.redirect_pc;
`else
   assign w_misalign    = 1'b0;
   assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

   // NOTE: every signal written here gets a default first, so no path
   // through the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_deq         = 1'b0;
      w_enq         = 1'b0;
      w_new         = '0;
      w_rd_ptr_next = r_rd_ptr;
      w_count_next  = r_count;
      w_head_next   = r_head;
      w_head_load   = 1'b0;

      w_deq = (r_count != 2'd0) && bus.out_ready;
      // A full queue may still accept a word when the head leaves this cycle.
      w_enq = !r_halt && ((r_count != 2'd2) || w_deq);

      w_new.pc    = r_pc;
      w_new.instr = w_misalign ? TRAP_INSTR : bus.imem_data;
      w_new.exc   = w_misalign;

      w_rd_ptr_next = r_rd_ptr ^ w_deq;
      w_count_next  = r_count + {1'b0, w_enq} - {1'b0, w_deq};

      // The head after this edge is either a resident entry or the word
      // being written right now (queue empty, or single entry leaving).
      if (w_enq && (w_rd_ptr_next == r_wr_ptr))
         w_head_next = w_new;
      else
         w_head_next = r_q[w_rd_ptr_next];

      // When the queue drains, the output registers keep the last head.
      w_head_load = !bus.redirect_valid && (w_count_next != 2'd0);
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_halt   <= 1'b0;
         r_head   <= '0;
      end else if (bus.redirect_valid) begin
         r_pc     <= w_redirect_pc;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_halt   <= 1'b0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= ~r_wr_ptr;
            // A trapped fetch stops the PC at the faulting address.
            if (w_misalign)
               r_halt <= 1'b1;
            else
               r_pc <= r_pc + 32'd4;
         end
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= w_count_next;
         if (w_head_load)
            r_head <= w_head_next;
      end
   end

   // NOTE: queue storage has no reset; r_count gates validity and the
   // outputs come from r_head, which is reset.
   always_ff @(posedge clk) begin
      if (!bus.redirect_valid && w_enq)
         r_q[r_wr_ptr] <= w_new;
   end

   assign bus.imem_addr = r_pc;
   assign bus.out_valid = (r_count != 2'd0);
   assign bus.out_instr = r_head.instr;
   assign bus.out_pc    = r_head.pc;
   assign bus.out_exc   = r_head.exc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural model (a queue of fetched
// entries plus a PC) predicts the decode-side outputs each cycle; directed
// steps cover reset, streaming, backpressure, redirect, PC wrap, misaligned
// targets and mid-stream reset, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: fixed words at 0/4/8, hashed elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_0011;
         32'h4:   return 32'h0000_0022;
         32'h8:   return 32'h0000_0033;
         default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   assign bus.imem_data = mem_word(bus.imem_addr);

   // Reference model
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } ent_t;

   ent_t        m_q [$];
   logic [31:0] m_pc;
   bit          m_halt;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
   endtask

   // One clock edge of the fetch stage, from the current inputs.
   task automatic model_edge();
      ent_t e;
      bit   deq;
      bit   enq;
      if (bus.redirect_valid) begin
         m_q.delete();
         m_halt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         m_pc = bus.redirect_pc;
`else
         m_pc = {bus.redirect_pc[31:2], 2'b00};
`endif
      end else begin
         deq = (m_q.size() > 0) && bus.out_ready;
         enq = !m_halt && ((m_q.size() < 2) || deq);
         if (deq) void'(m_q.pop_front());
         if (enq) begin
            e.pc = m_pc;
            if (m_pc[1:0] != 2'b00) begin
               e.instr = 32'h0000_0013;
               e.exc   = 1'b1;
               m_halt  = 1'b1;
            end else begin
               e.instr = mem_word(m_pc);
               e.exc   = 1'b0;
               m_pc    = m_pc + 32'd4;
            end
            m_q.push_back(e);
         end
      end
   endtask

   task automatic check_model();
      check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      if (!m_halt) check("imem_addr", bus.imem_addr, m_pc);
      if (m_q.size() != 0) begin
         check("out_pc", bus.out_pc, m_q[0].pc);
         check("out_instr", bus.out_instr, m_q[0].instr);
         check("out_exc", 32'(bus.out_exc), 32'(m_q[0].exc));
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      cycle();
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] target;

      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.out_ready      = 1'b1;
      rst_n              = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'h0);
      check("rst_addr", bus.imem_addr, RESET_PC);
      check("rst_instr", bus.out_instr, 32'h0);
      check("rst_pc", bus.out_pc, 32'h0);
      check("rst_exc", 32'(bus.out_exc), 32'h0);

      // Release between edges; stream 0/4/8
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      check("s0_pc", bus.out_pc, 32'h0);
      check("s0_instr", bus.out_instr, 32'h11);
      cycle();
      check("s1_pc", bus.out_pc, 32'h4);
      check("s1_instr", bus.out_instr, 32'h22);
      cycle();
      check("s2_pc", bus.out_pc, 32'h8);
      check("s2_instr", bus.out_instr, 32'h33);

      // Backpressure from the first valid word of a fresh stream at 0
      redirect(32'h0);
      cycle();
      bus.out_ready = 1'b0;
      repeat (5) cycle();
      check("bp_addr", bus.imem_addr, 32'h8);
      check("bp_head", bus.out_pc, 32'h0);
      bus.out_ready = 1'b1;
      cycle();
      check("drain_4", bus.out_pc, 32'h4);
      cycle();
      check("drain_8", bus.out_pc, 32'h8);
      cycle();

      // Redirect while the queue is full and decode is ready
      bus.out_ready = 1'b0;
      repeat (2) cycle();
      bus.out_ready = 1'b1;
      redirect(32'h100);
      check("redir_gap", 32'(bus.out_valid), 32'h0);
      cycle();
      check("redir_pc", bus.out_pc, 32'h100);
      repeat (3) cycle();

      // PC wrap
      redirect(32'hFFFF_FFFC);
      cycle();
      check("wrap_0", bus.out_pc, 32'hFFFF_FFFC);
      cycle();
      check("wrap_1", bus.out_pc, 32'h0000_0000);
      cycle();
      check("wrap_2", bus.out_pc, 32'h0000_0004);

      // Misaligned redirect
      redirect(32'h102);
      cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
      check("mis_pc", bus.out_pc, 32'h102);
      check("mis_exc", 32'(bus.out_exc), 32'h1);
      check("mis_instr", bus.out_instr, 32'h13);
      repeat (4) cycle();
      check("mis_halt", 32'(bus.out_valid), 32'h0);
      redirect(32'h200);
      cycle();
      check("mis_resume", bus.out_pc, 32'h200);
`else
      check("mis_pc", bus.out_pc, 32'h100);
      check("mis_exc", 32'(bus.out_exc), 32'h0);
`endif
      repeat (2) cycle();

      // Asynchronous reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'h0);
      check("arst_addr", bus.imem_addr, RESET_PC);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      check("arst_pc", bus.out_pc, 32'h0);
      check("arst_instr", bus.out_instr, 32'h11);
      repeat (3) cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            target = $urandom();
            if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
            redirect(target);
         end else begin
            cycle();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
